// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer with a single output register stage.
// Selection is either a fixed external index or round-robin over valid channels.
module stream_mux_rr #(
   parameter int W  = 8,
   parameter int N  = 4,
   parameter int SW = 2
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [N-1:0]    A_VALID,
   input  logic [N*W-1:0]  A_DATA,
   output logic [N-1:0]    A_READY,
   input  logic [SW-1:0]   S,
   input  logic            MODE,
   output logic            Y_VALID,
   output logic [W-1:0]    Y_DATA,
   output logic [SW-1:0]   Y_SEL,
   input  logic            Y_READY
);

   logic            y_vld_p1;
   logic [W-1:0]    y_data_p1;
   logic [SW-1:0]   y_sel_p1;
   logic [SW-1:0]   rr_ptr;

   logic            fix_vld_p0;
   logic            rr_vld_p0;
   logic [SW-1:0]   rr_idx_p0;
   logic            gnt_vld_p0;
   logic [SW-1:0]   gnt_idx_p0;
   logic [W-1:0]    gnt_data_p0;
   logic            load_p0;

   // Stage p0: grant selection, combinational from inputs and current state
   always_comb begin
      fix_vld_p0 = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (S == SW'(i)) fix_vld_p0 = A_VALID[i];
      end
   end

   // Search order starts at the pointer and wraps; the first valid hit wins.
   always_comb begin
      rr_vld_p0 = 1'b0;
      rr_idx_p0 = '0;
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!rr_vld_p0 && ((int'(rr_ptr) + k) % N == i) && A_VALID[i]) begin
               rr_vld_p0 = 1'b1;
               rr_idx_p0 = SW'(i);
            end
         end
      end
   end

   always_comb begin
      gnt_vld_p0 = MODE ? rr_vld_p0 : fix_vld_p0;
      gnt_idx_p0 = MODE ? rr_idx_p0 : S;
   end

   always_comb begin
      gnt_data_p0 = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_idx_p0 == SW'(i)) gnt_data_p0 = A_DATA[i*W +: W];
      end
   end

   assign load_p0 = !y_vld_p1 || Y_READY;

   always_comb begin
      A_READY = '0;
      for (int i = 0; i < N; i++) begin
         A_READY[i] = !RST && load_p0 && gnt_vld_p0 && (gnt_idx_p0 == SW'(i));
      end
   end

   // Stage p1: output register and round-robin pointer
   always_ff @(posedge CLK) begin
      if (RST) begin
         y_vld_p1  <= 1'b0;
         y_data_p1 <= '0;
         y_sel_p1  <= '0;
         rr_ptr    <= '0;
      end else if (load_p0) begin
         if (gnt_vld_p0) begin
            y_vld_p1  <= 1'b1;
            y_data_p1 <= gnt_data_p0;
            y_sel_p1  <= gnt_idx_p0;
            rr_ptr    <= (gnt_idx_p0 == SW'(N-1)) ? '0 : gnt_idx_p0 + SW'(1);
         end else begin
            y_vld_p1  <= 1'b0;
         end
      end
   end

   assign Y_VALID = y_vld_p1;
   assign Y_DATA  = y_data_p1;
   assign Y_SEL   = y_sel_p1;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: reset, fixed select, round-robin order,
// skip of idle channels, backpressure hold and mid-stream reset.
module tb_stream_mux_rr;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    a_valid;
   logic [N*W-1:0]  a_data;
   logic [N-1:0]    a_ready;
   logic [SW-1:0]   s;
   logic            mode;
   logic            y_valid;
   logic [W-1:0]    y_data;
   logic [SW-1:0]   y_sel;
   logic            y_ready;

   int n_cmp  = 0;
   int n_fail = 0;

   stream_mux_rr #(.W(W), .N(N), .SW(SW)) dut (
      .CLK     (clk),
      .RST     (rst),
      .A_VALID (a_valid),
      .A_DATA  (a_data),
      .A_READY (a_ready),
      .S       (s),
      .MODE    (mode),
      .Y_VALID (y_valid),
      .Y_DATA  (y_data),
      .Y_SEL   (y_sel),
      .Y_READY (y_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance past the next rising edge; inputs change 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      #5000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [SW-1:0] rr_seq [6];
      logic [SW-1:0] skip_seq [3];
      rr_seq   = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      skip_seq = '{2'd3, 2'd0, 2'd3};

      rst     = 1'b1;
      a_valid = 4'b1111;
      a_data  = {8'h13, 8'h12, 8'h11, 8'h10};
      s       = '0;
      mode    = 1'b0;
      y_ready = 1'b1;

      // reset held for two cycles with every channel requesting
      tick(); settle();
      chk("rst_ready_c1", a_ready, 4'b0000);
      tick(); settle();
      chk("rst_ready_c2", a_ready, 4'b0000);
      chk("rst_yvalid", y_valid, 1'b0);
      chk("rst_ydata", y_data, 8'h00);
      chk("rst_ysel", y_sel, 2'd0);

      rst = 1'b0;
      a_valid = 4'b0000;
      settle();
      chk("idle_ready", a_ready, 4'b0000);
      tick(); settle();
      chk("idle_yvalid", y_valid, 1'b0);
      chk("idle_ydata", y_data, 8'h00);

      // fixed select of channel 2
      mode = 1'b0; s = 2'd2; a_valid = 4'b1111;
      a_data = {8'h13, 8'hA5, 8'h11, 8'h10};
      settle();
      chk("fix_ready", a_ready, 4'b0100);
      tick(); settle();
      chk("fix_yvalid", y_valid, 1'b1);
      chk("fix_ydata", y_data, 8'hA5);
      chk("fix_ysel", y_sel, 2'd2);
      a_valid = 4'b1011;
      settle();
      chk("fix_nogrant_ready", a_ready, 4'b0000);
      tick(); settle();
      chk("fix_nogrant_yvalid", y_valid, 1'b0);
      chk("fix_nogrant_ydata_hold", y_data, 8'hA5);

      // round robin from pointer 3: 3,0,1,2,3,0
      mode = 1'b1; a_valid = 4'b1111;
      a_data = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int k = 0; k < 6; k++) begin
         settle();
         chk($sformatf("rr_ready_%0d", k), a_ready, 4'b0001 << rr_seq[k]);
         tick(); settle();
         chk($sformatf("rr_ysel_%0d", k), y_sel, rr_seq[k]);
         chk($sformatf("rr_ydata_%0d", k), y_data, 8'h10 + rr_seq[k]);
         chk($sformatf("rr_yvalid_%0d", k), y_valid, 1'b1);
      end

      // pointer now 1; only channels 0 and 3 request
      a_valid = 4'b1001;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk($sformatf("skip_ready_%0d", k), a_ready, 4'b0001 << skip_seq[k]);
         tick(); settle();
         chk($sformatf("skip_ysel_%0d", k), y_sel, skip_seq[k]);
      end

      // load 0x3C from channel 1 (pointer becomes 2), then stall
      mode = 1'b0; s = 2'd1; a_valid = 4'b0010;
      a_data = {8'h13, 8'h12, 8'h3C, 8'h10};
      tick(); settle();
      chk("bp_load_ydata", y_data, 8'h3C);
      y_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         a_valid = (k % 2 == 1) ? 4'b1111 : 4'b0101;
         s = SW'(k);
         mode = k[0];
         a_data = {8'h5A, 8'h6B, 8'h7C, 8'h8D} + 32'(k);
         settle();
         chk($sformatf("bp_ready_%0d", k), a_ready, 4'b0000);
         tick(); settle();
         chk($sformatf("bp_ydata_%0d", k), y_data, 8'h3C);
         chk($sformatf("bp_ysel_%0d", k), y_sel, 2'd1);
         chk($sformatf("bp_yvalid_%0d", k), y_valid, 1'b1);
      end
      y_ready = 1'b1; mode = 1'b1; a_valid = 4'b1111;
      a_data = {8'h13, 8'h12, 8'h11, 8'h10};
      settle();
      chk("bp_release_ready", a_ready, 4'b0100);
      tick(); settle();
      chk("bp_release_ysel", y_sel, 2'd2);
      chk("bp_release_ydata", y_data, 8'h12);

      // reset while a word is held
      y_ready = 1'b0; rst = 1'b1;
      settle();
      chk("mid_rst_ready", a_ready, 4'b0000);
      tick(); settle();
      chk("mid_rst_yvalid", y_valid, 1'b0);
      chk("mid_rst_ysel", y_sel, 2'd0);
      chk("mid_rst_ydata", y_data, 8'h00);
      rst = 1'b0; y_ready = 1'b1; mode = 1'b1; a_valid = 4'b1111;
      settle();
      chk("post_rst_ready", a_ready, 4'b0001);
      tick(); settle();
      chk("post_rst_ysel", y_sel, 2'd0);
      chk("post_rst_ydata", y_data, 8'h10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
